// File: rtl/matmul_input_loader.sv
// Fetches W then X from RAM row by row and holds them for the matmul FSM until fsm_ack; start is ignored while busy.
// Each row takes 1+MEM_ACCESS_LATENCY cycles. Define LOADER_WEIGHT_TRANSPOSE_EN to present W^T instead of W.
`ifndef MEM_PORT_WIDTH
`define MEM_PORT_WIDTH 128
`endif
`ifndef MEM_ADDR_INCR
`define MEM_ADDR_INCR 32'd16
`endif
`ifndef WEIGHT_MAT_BASE_ADDR
`define WEIGHT_MAT_BASE_ADDR 32'h0000_1000
`endif
`ifndef INPUT_MAT_BASE_ADDR
`define INPUT_MAT_BASE_ADDR 32'h0000_2000
`endif

module matmul_input_loader #(
  parameter int ROWS               = 4,
  parameter int COLS               = 4,
  parameter int WORD_SIZE          = 16,
  parameter int MEM_ACCESS_LATENCY = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic [31:0]                     mem_addr,
  output logic                            mem_rd_en,
  input  logic [`MEM_PORT_WIDTH-1:0]      mem_rd_data,
  output logic [ROWS*COLS*WORD_SIZE-1:0]  w_mat,
  output logic [ROWS*COLS*WORD_SIZE-1:0]  x_mat,
  output logic                            mats_valid,
  input  logic                            fsm_ack,
  output logic                            load_busy,
  output logic                            load_done
);

  localparam int ROW_W  = COLS * WORD_SIZE;
  localparam int RIDX_W = $clog2(ROWS) + 1;
  localparam int CNT_W  = $clog2(MEM_ACCESS_LATENCY) + 1;

  typedef enum logic [2:0] {IDLE, RD_W, RD_W_WAIT, RD_X, RD_X_WAIT, PRESENT} state_t;

  state_t                     state;
  logic [RIDX_W-1:0]          row_idx;
  logic [CNT_W-1:0]           dly_cnt;
  logic [ROW_W-1:0]           rd_row;
  logic                       last_row;
  logic [`MEM_PORT_WIDTH-1:0] rd_data_unused;

  // Only the low COLS*WORD_SIZE bits of the RAM word carry a matrix row.
  assign rd_row         = mem_rd_data[ROW_W-1:0];
  assign rd_data_unused = mem_rd_data;
  assign last_row       = (row_idx == RIDX_W'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row_idx    <= '0;
      dly_cnt    <= '0;
      mem_addr   <= '0;
      mem_rd_en  <= 1'b0;
      w_mat      <= '0;
      x_mat      <= '0;
      mats_valid <= 1'b0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RD_W;
            row_idx   <= '0;
            load_busy <= 1'b1;
          end
        end
        RD_W: begin
          mem_addr  <= `WEIGHT_MAT_BASE_ADDR + 32'(row_idx) * `MEM_ADDR_INCR;
          mem_rd_en <= 1'b1;
          dly_cnt   <= CNT_W'(MEM_ACCESS_LATENCY - 1);
          state     <= RD_W_WAIT;
        end
        RD_W_WAIT: begin
          mem_rd_en <= 1'b0;
          if (dly_cnt != '0) begin
            dly_cnt <= dly_cnt - 1'b1;
          end else begin
            for (int r = 0; r < ROWS; r++) begin
              if (row_idx == RIDX_W'(r)) begin
                for (int c = 0; c < COLS; c++) begin
`ifdef LOADER_WEIGHT_TRANSPOSE_EN
                  w_mat[(c*ROWS+r)*WORD_SIZE +: WORD_SIZE] <= rd_row[c*WORD_SIZE +: WORD_SIZE];
`else
                  w_mat[(r*COLS+c)*WORD_SIZE +: WORD_SIZE] <= rd_row[c*WORD_SIZE +: WORD_SIZE];
`endif
                end
              end
            end
            if (last_row) begin
              row_idx <= '0;
              state   <= RD_X;
            end else begin
              row_idx <= row_idx + 1'b1;
              state   <= RD_W;
            end
          end
        end
        RD_X: begin
          mem_addr  <= `INPUT_MAT_BASE_ADDR + 32'(row_idx) * `MEM_ADDR_INCR;
          mem_rd_en <= 1'b1;
          dly_cnt   <= CNT_W'(MEM_ACCESS_LATENCY - 1);
          state     <= RD_X_WAIT;
        end
        RD_X_WAIT: begin
          mem_rd_en <= 1'b0;
          if (dly_cnt != '0) begin
            dly_cnt <= dly_cnt - 1'b1;
          end else begin
            for (int r = 0; r < ROWS; r++) begin
              if (row_idx == RIDX_W'(r)) begin
                x_mat[r*ROW_W +: ROW_W] <= rd_row;
              end
            end
            if (last_row) begin
              row_idx    <= '0;
              mats_valid <= 1'b1;
              state      <= PRESENT;
            end else begin
              row_idx <= row_idx + 1'b1;
              state   <= RD_X;
            end
          end
        end
        PRESENT: begin
          if (fsm_ack) begin
            mats_valid <= 1'b0;
            load_busy  <= 1'b0;
            load_done  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_input_loader.sv
// Bench for matmul_input_loader: RAM model with fixed read latency, matrix/address reference model.
`ifndef MEM_PORT_WIDTH
`define MEM_PORT_WIDTH 128
`endif
`ifndef MEM_ADDR_INCR
`define MEM_ADDR_INCR 32'd16
`endif
`ifndef WEIGHT_MAT_BASE_ADDR
`define WEIGHT_MAT_BASE_ADDR 32'h0000_1000
`endif
`ifndef INPUT_MAT_BASE_ADDR
`define INPUT_MAT_BASE_ADDR 32'h0000_2000
`endif

module tb_matmul_input_loader;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int WS       = 16;
  localparam int LAT      = 2;
  localparam int MPW      = `MEM_PORT_WIDTH;
  localparam int MAT_W    = ROWS * COLS * WS;
  localparam int LOAD_CYC = 2 * ROWS * (1 + LAT);
  localparam logic [MPW-1:0] GARBAGE = {(MPW/8){8'hA5}};

  logic             clk;
  logic             rst;
  logic             start;
  logic [31:0]      mem_addr;
  logic             mem_rd_en;
  logic [MPW-1:0]   mem_rd_data;
  logic [MAT_W-1:0] w_mat;
  logic [MAT_W-1:0] x_mat;
  logic             mats_valid;
  logic             fsm_ack;
  logic             load_busy;
  logic             load_done;

  matmul_input_loader #(
    .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WS), .MEM_ACCESS_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .w_mat(w_mat), .x_mat(x_mat), .mats_valid(mats_valid),
    .fsm_ack(fsm_ack), .load_busy(load_busy), .load_done(load_done)
  );

  logic [WS-1:0]  ram_w [ROWS][COLS];
  logic [WS-1:0]  ram_x [ROWS][COLS];
  logic [31:0]    rd_log [$];
  logic [MPW-1:0] ram_pipe [LAT];
  int             errors = 0;
  int             checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // RAM contents as seen at a byte address; unmapped addresses return a filler pattern.
  function automatic logic [MPW-1:0] ram_row(input logic [31:0] a);
    logic [MPW-1:0] d;
    d = {(MPW/16){16'hBEEF}};
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (a == `WEIGHT_MAT_BASE_ADDR + 32'(r) * `MEM_ADDR_INCR) d[c*WS +: WS] = ram_w[r][c];
        else if (a == `INPUT_MAT_BASE_ADDR + 32'(r) * `MEM_ADDR_INCR) d[c*WS +: WS] = ram_x[r][c];
      end
    end
    return d;
  endfunction

  // Data is valid exactly LAT cycles after the read strobe; garbage otherwise.
  always @(posedge clk) begin
    ram_pipe[0] <= mem_rd_en ? ram_row(mem_addr) : GARBAGE;
    for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end

  generate
    if (LAT == 1) begin : g_lat1
      assign mem_rd_data = mem_rd_en ? ram_row(mem_addr) : GARBAGE;
    end else begin : g_latn
      assign mem_rd_data = ram_pipe[LAT-2];
    end
  endgenerate

  always @(negedge clk) begin
    if (mem_rd_en) rd_log.push_back(mem_addr);
  end

  task automatic chk(input string tag, input logic [MAT_W-1:0] got, input logic [MAT_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_ram(input bit rnd);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        ram_w[r][c] = rnd ? WS'($urandom) : WS'(16*r + c);
        ram_x[r][c] = rnd ? WS'($urandom) : WS'(256 + 16*r + c);
      end
    end
  endtask

  // Matrix the FSM should see: element [i][j] packed at (i*COLS+j).
  function automatic logic [MAT_W-1:0] exp_w();
    logic [MAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
`ifdef LOADER_WEIGHT_TRANSPOSE_EN
        m[(i*COLS+j)*WS +: WS] = ram_w[j][i];
`else
        m[(i*COLS+j)*WS +: WS] = ram_w[i][j];
`endif
      end
    end
    return m;
  endfunction

  function automatic logic [MAT_W-1:0] exp_x();
    logic [MAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        m[(i*COLS+j)*WS +: WS] = ram_x[i][j];
    return m;
  endfunction

  function automatic logic [31:0] exp_addr(input int i);
    if (i < ROWS) return `WEIGHT_MAT_BASE_ADDR + 32'(i) * `MEM_ADDR_INCR;
    return `INPUT_MAT_BASE_ADDR + 32'(i - ROWS) * `MEM_ADDR_INCR;
  endfunction

  task automatic do_load(input int ack_dly, input bit noise, input bit start_with_ack);
    int n;
    bit seen;
    rd_log.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    seen = 1'b0;
    chk("busy_on_start", load_busy, 1);
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      start   = noise && (n == 3 || n == 10);
      fsm_ack = noise && (n == 5);
      if (mats_valid) seen = 1'b1;
    end
    start   = 1'b0;
    fsm_ack = 1'b0;
    chk("mv_cycle", n, LOAD_CYC);
    chk("busy_load", load_busy, 1);
    chk("rd_count", rd_log.size(), 2*ROWS);
    for (int i = 0; i < rd_log.size() && i < 2*ROWS; i++) chk("rd_addr", rd_log[i], exp_addr(i));
    chk("w_mat", w_mat, exp_w());
    chk("x_mat", x_mat, exp_x());
    repeat (ack_dly) @(negedge clk);
    chk("mv_hold", mats_valid, 1);
    chk("w_hold", w_mat, exp_w());
    fsm_ack = 1'b1;
    start   = start_with_ack;
    @(negedge clk);
    fsm_ack = 1'b0;
    start   = 1'b0;
    chk("mv_after_ack", mats_valid, 0);
    chk("done_pulse", load_done, 1);
    chk("busy_after_ack", load_busy, 0);
    @(negedge clk);
    chk("done_end", load_done, 0);
    repeat (3) @(negedge clk);
    chk("no_reload", rd_log.size(), 2*ROWS);
    chk("busy_idle", load_busy, 0);
    chk("w_retain", w_mat, exp_w());
    chk("x_retain", x_mat, exp_x());
  endtask

  // Abort while X row 2 is waiting for data; its read strobe has already been issued.
  task automatic abort_test();
    int n;
    fill_ram(1'b1);
    rd_log.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (n < 3*(ROWS+2) + 1) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rd_en", mem_rd_en, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_mv", mats_valid, 0);
    chk("abort_busy", load_busy, 0);
    chk("abort_done", load_done, 0);
    chk("abort_w", w_mat, 0);
    chk("abort_x", x_mat, 0);
    chk("abort_reads", rd_log.size(), ROWS + 3);
    repeat (30) @(negedge clk);
    chk("abort_idle_reads", rd_log.size(), ROWS + 3);
    chk("abort_idle_mv", mats_valid, 0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    fsm_ack = 1'b0;
    fill_ram(1'b0);
    repeat (3) @(negedge clk);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_mv", mats_valid, 0);
    chk("rst_busy", load_busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_w", w_mat, 0);
    chk("rst_x", x_mat, 0);
    rst = 1'b0;

    do_load(5, 1'b0, 1'b0);
    fill_ram(1'b1);
    do_load(0, 1'b1, 1'b1);
    abort_test();
    for (int k = 0; k < 4; k++) begin
      fill_ram(1'b1);
      do_load(int'($urandom_range(0, 6)), k[0], k[1]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
